// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Sequences a PLL out of reset and then releases the downstream clock-domain
//   resets one after another. If lock never arrives, the PLL reset is retried
//   a bounded number of times before the block reports failure. Any loss of
//   lock while the channels are released or running puts every channel back
//   into reset and waits for lock again. That path does not pulse the PLL
//   reset.
//
// Ports
//   clkin1    in   supervisor clock (PLL reference clock)
//   rst       in   asynchronous active-high reset
//   pll_lock  in   PLL LOCK, asynchronous to clkin1
//   restart   in   single-cycle request to rerun the whole sequence
//   clr_lost  in   clears the sticky lost_lock flag
//   pll_rst   out  PLL reset, active high
//   ch_rst    out  per-domain resets, active high, channel 0 released first
//   locked    out  all channels released and lock stable
//   lost_lock out  sticky loss-of-lock flag
//   fail      out  PLL reset retries exhausted
//   retry_cnt out  retries used since the last rst or restart
module pll_lock_supervisor #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned LOCK_FILTER  = 64,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned RST_PULSE    = 16,
  parameter int unsigned STAGE_DELAY  = 32,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                clkin1,
  input  logic                rst,
  input  logic                pll_lock,
  input  logic                restart,
  input  logic                clr_lost,
  output logic                pll_rst,
  output logic [CHANNELS-1:0] ch_rst,
  output logic                locked,
  output logic                lost_lock,
  output logic                fail,
  output logic [3:0]          retry_cnt
);

  localparam int unsigned SC_MAX = 1 + (CHANNELS - 1) * STAGE_DELAY;
  localparam int unsigned PW = $clog2(RST_PULSE + 1);
  localparam int unsigned FW = $clog2(LOCK_FILTER + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned SW = $clog2(SC_MAX + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  localparam logic [PW-1:0] PULSE_TC = PW'(RST_PULSE);
  localparam logic [FW-1:0] FILT_TC  = FW'(LOCK_FILTER);
  localparam logic [TW-1:0] TMO_TC   = TW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0] SC_TC    = SW'(SC_MAX);
  localparam logic [RW-1:0] RETRY_TC = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t state, state_nxt;

  logic          sync1, lk;
  logic [PW-1:0] pc, pc_nxt, pc_inc;
  logic [FW-1:0] filt, filt_nxt, filt_inc;
  logic [TW-1:0] tmo, tmo_nxt, tmo_inc;
  logic [SW-1:0] sc, sc_nxt, sc_inc;
  logic [RW-1:0] retry, retry_nxt;
  logic          lost_set;
  logic [CHANNELS-1:0] ch_rst_nxt;

  // Two-flop synchroniser for the asynchronous lock indication.
  always_ff @(posedge clkin1 or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_lock;
      lk    <= sync1;
    end
  end

  always_ff @(posedge clkin1 or posedge rst) begin
    if (rst) state <= S_RESET_PLL;
    else     state <= state_nxt;
  end

  // Saturating increments; each counter is judged on its incremented value
  // so a terminal count acts on the edge where it is reached.
  always_comb begin
    pc_inc   = (pc   == PULSE_TC) ? pc   : pc   + PW'(1);
    filt_inc = (filt == FILT_TC)  ? filt : filt + FW'(1);
    tmo_inc  = (tmo  == TMO_TC)   ? tmo  : tmo  + TW'(1);
    sc_inc   = (sc   == SC_TC)    ? sc   : sc   + SW'(1);
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    filt_nxt  = filt;
    tmo_nxt   = tmo;
    sc_nxt    = sc;
    retry_nxt = retry;
    lost_set  = 1'b0;

    if (restart) begin
      state_nxt = S_RESET_PLL;
      pc_nxt    = '0;
      filt_nxt  = '0;
      tmo_nxt   = '0;
      sc_nxt    = '0;
      retry_nxt = '0;
    end else begin
      unique case (state)
        S_RESET_PLL: begin
          if (pc_inc == PULSE_TC) begin
            state_nxt = S_WAIT_LOCK;
            pc_nxt    = '0;
            filt_nxt  = '0;
            tmo_nxt   = '0;
          end else begin
            pc_nxt = pc_inc;
          end
        end
        S_WAIT_LOCK: begin
          filt_nxt = lk ? filt_inc : '0;
          tmo_nxt  = tmo_inc;
          // Filter completion is tested first so it wins a tie with timeout.
          if (lk && filt_inc == FILT_TC) begin
            state_nxt = S_RELEASE;
            sc_nxt    = '0;
          end else if (tmo_inc == TMO_TC) begin
            if (retry < RETRY_TC) begin
              retry_nxt = retry + RW'(1);
              state_nxt = S_RESET_PLL;
              pc_nxt    = '0;
            end else begin
              state_nxt = S_FAIL;
            end
          end
        end
        S_RELEASE, S_RUN: begin
          if (!lk) begin
            lost_set  = 1'b1;
            state_nxt = S_WAIT_LOCK;
            filt_nxt  = '0;
            tmo_nxt   = '0;
            sc_nxt    = '0;
          end else if (state == S_RELEASE) begin
            sc_nxt = sc_inc;
            if (sc_inc == SC_TC) state_nxt = S_RUN;
          end
        end
        S_FAIL: begin
          state_nxt = S_FAIL;
        end
        default: begin
          state_nxt = S_RESET_PLL;
        end
      endcase
    end
  end

  // The stage counter reads 1 on the first edge after entering RELEASE,
  // so channel k drops once it reaches 1 + k*STAGE_DELAY.
  always_comb begin
    ch_rst_nxt = '1;
    if (state_nxt == S_RUN) begin
      ch_rst_nxt = '0;
    end else if (state_nxt == S_RELEASE) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        ch_rst_nxt[k] = !(32'(sc_nxt) >= 1 + k * STAGE_DELAY);
      end
    end
  end

  always_ff @(posedge clkin1 or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      filt      <= '0;
      tmo       <= '0;
      sc        <= '0;
      retry     <= '0;
      pll_rst   <= 1'b1;
      ch_rst    <= '1;
      locked    <= 1'b0;
      lost_lock <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      pc        <= pc_nxt;
      filt      <= filt_nxt;
      tmo       <= tmo_nxt;
      sc        <= sc_nxt;
      retry     <= retry_nxt;
      pll_rst   <= (state_nxt == S_RESET_PLL);
      ch_rst    <= ch_rst_nxt;
      locked    <= (state_nxt == S_RUN);
      lost_lock <= lost_set | (lost_lock & ~clr_lost);
      fail      <= (state_nxt == S_FAIL);
      retry_cnt <= 4'(retry_nxt);
    end
  end

endmodule
